// File: rtl/bresenham_octant_unfold_if.sv
// bresenham_octant_unfold_if: command and point stream bundle for the octant-unfolding line walker.
interface bresenham_octant_unfold_if #(
    parameter int COORD_W = 16,
    parameter int LEN_W = 12
) ();
    logic cmd_valid;
    logic cmd_ready;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [LEN_W-1:0] cmd_dx;
    logic [LEN_W-1:0] cmd_dy;
    logic cmd_flip_y;
    logic cmd_flip_x;
    logic cmd_flip_identity;
    logic pt_valid;
    logic pt_ready;
    logic [COORD_W-1:0] pt_x;
    logic [COORD_W-1:0] pt_y;
    logic pt_last;
    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_dx, cmd_dy, cmd_flip_y, cmd_flip_x, cmd_flip_identity, pt_ready,
        input cmd_ready, pt_valid, pt_x, pt_y, pt_last
    );
    modport slave (
        input cmd_valid, cmd_x0, cmd_y0, cmd_dx, cmd_dy, cmd_flip_y, cmd_flip_x, cmd_flip_identity, pt_ready,
        output cmd_ready, pt_valid, pt_x, pt_y, pt_last
    );
endinterface

// File: rtl/bresenham_octant_unfold.sv
// bresenham_octant_unfold: walks a first-octant Bresenham segment and unfolds each point to absolute cells.
module bresenham_octant_unfold #(
    parameter int COORD_W = 16,
    parameter int LEN_W = 12
) (
    input logic clk,
    input logic reset,
    bresenham_octant_unfold_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [LEN_W-1:0] dx_q, dx_d, dy_q, dy_d, i_q, i_d, j_q, j_d;
    logic flip_y_q, flip_y_d, flip_x_q, flip_x_d, flip_id_q, flip_id_d;
    logic [LEN_W+1:0] err_q, err_d;
    logic [LEN_W-1:0] dy_clamp, u_mag, v_mag;
    logic [COORD_W-1:0] u, v;
    logic last, err_pos;
    always_comb begin
        dy_clamp = bus.cmd_dy > bus.cmd_dx ? bus.cmd_dx : bus.cmd_dy;
        // unfold undoes the reduction in reverse: axis swap first, then the sign flips
        u_mag = flip_id_q ? j_q : i_q;
        v_mag = flip_id_q ? i_q : j_q;
        u = flip_x_q ? -COORD_W'(u_mag) : COORD_W'(u_mag);
        v = flip_y_q ? -COORD_W'(v_mag) : COORD_W'(v_mag);
        last = state_q == RUN && i_q == dx_q;
        err_pos = !err_q[LEN_W+1] && err_q != '0;
        bus.cmd_ready = state_q == IDLE;
        bus.pt_valid = state_q == RUN;
        bus.pt_x = x0_q + u;
        bus.pt_y = y0_q + v;
        bus.pt_last = last;
        state_d = state_q;
        x0_d = x0_q;
        y0_d = y0_q;
        dx_d = dx_q;
        dy_d = dy_q;
        flip_y_d = flip_y_q;
        flip_x_d = flip_x_q;
        flip_id_d = flip_id_q;
        i_d = i_q;
        j_d = j_q;
        err_d = err_q;
        if (state_q == IDLE && bus.cmd_valid) begin
            state_d = RUN;
            x0_d = bus.cmd_x0;
            y0_d = bus.cmd_y0;
            dx_d = bus.cmd_dx;
            dy_d = dy_clamp;
            flip_y_d = bus.cmd_flip_y;
            flip_x_d = bus.cmd_flip_x;
            flip_id_d = bus.cmd_flip_identity;
            i_d = '0;
            j_d = '0;
            err_d = {1'b0, dy_clamp, 1'b0} - {2'b00, bus.cmd_dx};
        end else if (state_q == RUN && bus.pt_ready) begin
            state_d = last ? IDLE : RUN;
            i_d = last ? i_q : i_q + 1'b1;
            j_d = !last && err_pos ? j_q + 1'b1 : j_q;
            err_d = last ? err_q : err_q + {1'b0, dy_q, 1'b0} - (err_pos ? {1'b0, dx_q, 1'b0} : '0);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q <= '0;
            y0_q <= '0;
            dx_q <= '0;
            dy_q <= '0;
            flip_y_q <= 1'b0;
            flip_x_q <= 1'b0;
            flip_id_q <= 1'b0;
            i_q <= '0;
            j_q <= '0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            x0_q <= x0_d;
            y0_q <= y0_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            flip_y_q <= flip_y_d;
            flip_x_q <= flip_x_d;
            flip_id_q <= flip_id_d;
            i_q <= i_d;
            j_q <= j_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_bresenham_octant_unfold.sv
// tb_bresenham_octant_unfold: directed and random segments checked against a closed-form line model.
module tb_bresenham_octant_unfold;
    localparam int CW = 16;
    localparam int LW = 12;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int errors = 0;
    logic [CW-1:0] exp_x[$];
    logic [CW-1:0] exp_y[$];
    logic exp_l[$];
    bit pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};
    bresenham_octant_unfold_if #(.COORD_W(CW), .LEN_W(LW)) bus ();
    bresenham_octant_unfold #(.COORD_W(CW), .LEN_W(LW)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // minor coordinate is dy*i/dx rounded to nearest, ties rounding down
    task automatic build(input int x0, input int y0, input int dx, input int dy, input bit fy, input bit fx, input bit fi);
        int dyc, u, v, j;
        dyc = dy > dx ? dx : dy;
        for (int i = 0; i <= dx; i++) begin
            j = dx == 0 ? 0 : (2 * dyc * i + dx - 1) / (2 * dx);
            u = fi ? j : i;
            v = fi ? i : j;
            if (fx) u = -u;
            if (fy) v = -v;
            exp_x.push_back(CW'(x0 + u));
            exp_y.push_back(CW'(y0 + v));
            exp_l.push_back(i == dx);
        end
    endtask

    task automatic send_cmd(input int x0, input int y0, input int dx, input int dy, input bit fy, input bit fx, input bit fi);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_x0 = CW'(x0);
        bus.cmd_y0 = CW'(y0);
        bus.cmd_dx = LW'(dx);
        bus.cmd_dy = LW'(dy);
        bus.cmd_flip_y = fy;
        bus.cmd_flip_x = fx;
        bus.cmd_flip_identity = fi;
        build(x0, y0, dx, dy, fy, fx, fi);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("accept_latency_valid", 32'(bus.pt_valid), 1);
        check("busy_cmd_ready", 32'(bus.cmd_ready), 0);
    endtask

    // mode 0: always ready, 1: fixed stall pattern, 2: random ready
    task automatic drain(input int mode, input bit pulse);
        int cyc = 0;
        bit rdy;
        while (exp_x.size() > 0 && cyc < 200) begin
            check("pt_valid", 32'(bus.pt_valid), 1);
            check("pt_x", 32'(bus.pt_x), 32'(exp_x[0]));
            check("pt_y", 32'(bus.pt_y), 32'(exp_y[0]));
            check("pt_last", 32'(bus.pt_last), 32'(exp_l[0]));
            rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc < 8 ? pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
            bus.pt_ready = rdy;
            if (pulse && cyc == 2) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_x0 = 16'h1234;
                bus.cmd_dx = 12'd1;
            end else bus.cmd_valid = 1'b0;
            if (rdy) begin
                void'(exp_x.pop_front());
                void'(exp_y.pop_front());
                void'(exp_l.pop_front());
            end
            cyc++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.pt_ready = 1'b0;
        check("segment_complete", exp_x.size(), 0);
        check("idle_cmd_ready", 32'(bus.cmd_ready), 1);
        check("idle_pt_valid", 32'(bus.pt_valid), 0);
        exp_x.delete();
        exp_y.delete();
        exp_l.delete();
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0;
        bus.cmd_y0 = '0;
        bus.cmd_dx = '0;
        bus.cmd_dy = '0;
        bus.cmd_flip_y = 1'b0;
        bus.cmd_flip_x = 1'b0;
        bus.cmd_flip_identity = 1'b0;
        bus.pt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_pt_valid", 32'(bus.pt_valid), 0);
        check("rst_pt_last", 32'(bus.pt_last), 0);
        check("rst_pt_x", 32'(bus.pt_x), 0);
        check("rst_pt_y", 32'(bus.pt_y), 0);
        reset = 1'b0;
        @(negedge clk);
        send_cmd(10, 20, 4, 2, 0, 0, 0);
        drain(0, 0);
        send_cmd(10, 20, 4, 2, 1, 1, 1);
        drain(0, 0);
        send_cmd(0, 0, 3, 3, 0, 0, 1);
        drain(0, 0);
        send_cmd(0, 0, 2, 0, 0, 1, 0);
        drain(0, 0);
        send_cmd(-5, 7, 0, 0, 0, 0, 0);
        drain(0, 0);
        send_cmd(0, 0, 4, 2, 0, 0, 0);
        drain(1, 1);
        send_cmd(0, 0, 4, 2, 0, 0, 0);
        bus.pt_ready = 1'b1;
        @(negedge clk);
        check("pre_rst_pt_x", 32'(bus.pt_x), 32'(exp_x[1]));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.pt_ready = 1'b0;
        check("midrst_pt_valid", 32'(bus.pt_valid), 0);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("midrst_pt_last", 32'(bus.pt_last), 0);
        exp_x.delete();
        exp_y.delete();
        exp_l.delete();
        send_cmd(3, 3, 4, 2, 0, 0, 0);
        drain(0, 0);
        send_cmd(32767, 0, 1, 0, 0, 0, 0);
        drain(0, 0);
        send_cmd(100, -100, 3, 9, 0, 1, 0);
        drain(0, 0);
        for (int r = 0; r < 25; r++) begin
            int dx;
            dx = int'($urandom_range(0, 20));
            send_cmd(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), dx,
                     int'($urandom_range(0, dx + 2)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain(2, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bresenham_octant_unfold.md
Name: bresenham_octant_unfold

Overview:
- Streaming Bresenham point generator for the ray-casting path.
- Accepts a line segment already reduced to the first octant (major length dx, minor length dy, 0 ≤ dy ≤ dx), together with the three fold flags produced by the angle-reduction stage (flip_y, flip_x, flip_identity).
- Walks the segment in the reduced octant and undoes the folding on every point, in the inverse order of the reduction.
- Emits absolute grid-cell coordinates over a valid/ready stream to the map-update logic.

Parameters:
- COORD_W, 16, width of signed absolute cell coordinates (two's complement).
- LEN_W, 12, width of unsigned reduced-octant lengths dx and dy.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  segment command valid
- cmd_ready  out  1  block can accept a command
- cmd_x0  in  COORD_W  origin x, signed cell index
- cmd_y0  in  COORD_W  origin y, signed cell index
- cmd_dx  in  LEN_W  reduced major-axis length
- cmd_dy  in  LEN_W  reduced minor-axis length
- cmd_flip_y  in  1  negate final y
- cmd_flip_x  in  1  negate final x
- cmd_flip_identity  in  1  swap axes
- pt_valid  out  1  output point valid
- pt_ready  in  1  downstream accepts point
- pt_x  out  COORD_W  absolute x of point
- pt_y  out  COORD_W  absolute y of point
- pt_last  out  1  point is the segment end

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - cmd_ready = 1.
  - pt_valid = 0, pt_last = 0.
  - pt_x = 0, pt_y = 0.
  - All internal registers cleared.
- States: IDLE, RUN.
- IDLE:
  - cmd_ready = 1.
  - When cmd_valid, latch all cmd_* fields.
  - Initialise i = 0, j = 0, err = 2·dy − dx (signed, LEN_W+2 bits).
  - Go to RUN.
  - pt_valid rises on the cycle after acceptance (latency 1).
- RUN:
  - cmd_ready = 0.
  - pt_valid = 1, presenting the current (i, j) mapped through the unfold.
- Unfold, combinational from (i, j) and applied in this order:
  1. If flip_identity: (u, v) = (j, i), else (u, v) = (i, j).
  2. If flip_x: u = −u.
  3. If flip_y: v = −v.
  4. pt_x = x0 + u and pt_y = y0 + v, sign-extended, wrapping modulo 2^COORD_W with no saturation.
- pt_last = 1 when i == dx.
- Handshake:
  - Output fields hold stable while pt_valid && !pt_ready.
  - On pt_valid && pt_ready && !pt_last:
    - i += 1.
    - If err > 0: j += 1 and err += 2·dy − 2·dx.
    - Otherwise: err += 2·dy.
  - On pt_valid && pt_ready && pt_last: return to IDLE.
  - cmd_ready is asserted in the following cycle. No back-to-back command overlap; one idle cycle between segments.
- Throughput: one point per cycle while pt_ready is held high.
- Point count per segment = dx + 1.
- Boundary conditions:
  - dx = 0: single point (x0, y0) with pt_last = 1.
  - dy > dx is illegal; the block clamps dy to dx at latch time, giving a 45° diagonal.
  - dy = 0: straight line along the (unfolded) major axis.
  - dy = dx: exact diagonal, j increments every step after the first.
  - cmd_valid while in RUN is ignored; the command is not consumed.
  - Reset asserted mid-segment: block returns to the reset state on the next edge, pt_valid drops, and the segment is abandoned with no pt_last.
  - pt_ready may toggle arbitrarily; no points are dropped or duplicated.

Test Plan:
- No flips: origin (10,20), dx=4, dy=2, pt_ready=1. Required points: (10,20), (11,20), (12,21), (13,21), (14,22), with pt_last only on the 5th. First pt_valid one cycle after cmd accept.
- All flips set: same origin and lengths. Required points: (10,20), (10,19), (9,18), (9,17), (8,16).
- flip_identity only: origin (0,0), dx=3, dy=3. Required points: (0,0), (1,1), (2,2), (3,3). Then with flip_x only, dx=2, dy=0: (0,0), (−1,0), (−2,0).
- dx=0: origin (−5,7). Required: single point (−5,7) with pt_last=1. cmd_ready high again two cycles after accept.
- Backpressure: dx=4, dy=2, pt_ready pattern 1,0,0,1,0,1,1,1. Required: outputs held stable while stalled, exactly 5 points in order. cmd_valid pulsed during RUN is not accepted.
- Reset after 2nd point accepted: pt_valid=0 next cycle, cmd_ready=1. A new command then starts cleanly from i=0. Also cover wrap: origin (32767,0), dx=1, dy=0 → (32767,0), (−32768,0).
